// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the processor control unit.
// Opcodes, state encoding, ALU and bus-select codes.
package proc_pkg;

  localparam int NREG = 8;
  localparam int IW   = 9;

  localparam logic [2:0] OP_MV   = 3'd0;
  localparam logic [2:0] OP_MVI  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_SUB  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_MVNZ = 3'd5;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  localparam logic [3:0] SEL_G   = 4'd8;
  localparam logic [3:0] SEL_DIN = 4'd9;

  function automatic logic [1:0] alu_of(
    input logic [2:0] op
  );
    logic [1:0] r;
    r = ALU_ADD;
    if (op == OP_SUB) r = ALU_SUB;
    if (op == OP_AND) r = ALU_AND;
    return r;
  endfunction

endpackage

// File: rtl/proc_ctrl_if.sv
// Control-unit bundle: instruction side handshake,
// datapath enables, bus select and status.
interface proc_ctrl_if;
  import proc_pkg::*;

  logic            Run;
  logic [IW-1:0]   IR;
  logic            GZ;
  logic            IRin;
  logic [NREG-1:0] Rin;
  logic            Ain;
  logic            Gin;
  logic [1:0]      AluOp;
  logic [3:0]      BusSel;
  logic            Done;
  logic            Err;

  modport master (
    input  Run, IR, GZ,
    output IRin, Rin, Ain, Gin,
    output AluOp, BusSel, Done, Err
  );

  modport slave (
    output Run, IR, GZ,
    input  IRin, Rin, Ain, Gin,
    input  AluOp, BusSel, Done, Err
  );

endinterface

// File: rtl/proc_ctrl_dec3to8.sv
// 3-to-8 one-hot decoder with enable,
// used for the register load enables.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  assign y = en ? (8'b1 << sel) : 8'b0;

endmodule

// File: rtl/proc_ctrl.sv
// Bus-processor control unit: T0..T3 sequencer.
// Define PROC_CTRL_MVNZ_EN to enable opcode 101 (mvnz).
import proc_pkg::*;

module proc_ctrl (
  input  logic        Clock,
  input  logic        Resetn,
  proc_ctrl_if.master bus
);

  state_t     state;
  state_t     nxt;
  logic       err_q;
  logic       set_err;
  logic       rin_en;
  logic [2:0] op;
  logic [2:0] x;
  logic [2:0] y;
  logic       is_mv;
  logic       is_mvi;
  logic       is_alu;
  logic       is_mvnz;

  assign op = bus.IR[8:6];
  assign x  = bus.IR[5:3];
  assign y  = bus.IR[2:0];

  assign is_mv  = (op == OP_MV);
  assign is_mvi = (op == OP_MVI);
  assign is_alu = (op == OP_ADD) ||
                  (op == OP_SUB) ||
                  (op == OP_AND);

`ifdef PROC_CTRL_MVNZ_EN
  assign is_mvnz = (op == OP_MVNZ);
`else
  logic unused_gz;
  assign is_mvnz   = 1'b0;
  assign unused_gz = bus.GZ;
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= T0;
      err_q <= 1'b0;
    end else begin
      state <= nxt;
      if (set_err) err_q <= 1'b1;
    end
  end

  always_comb begin
    nxt        = state;
    set_err    = 1'b0;
    rin_en     = 1'b0;
    bus.IRin   = 1'b0;
    bus.Ain    = 1'b0;
    bus.Gin    = 1'b0;
    bus.AluOp  = ALU_ADD;
    bus.BusSel = 4'd0;
    bus.Done   = 1'b0;
    case (state)
      T0: begin
        // IR load must not fire while reset is held
        bus.IRin = bus.Run & Resetn;
        if (bus.Run) nxt = T1;
      end
      T1: begin
        unique case (1'b1)
          is_mv: begin
            bus.BusSel = {1'b0, y};
            rin_en     = 1'b1;
            bus.Done   = 1'b1;
            nxt        = T0;
          end
          is_mvi: begin
            bus.BusSel = SEL_DIN;
            rin_en     = 1'b1;
            bus.Done   = 1'b1;
            nxt        = T0;
          end
          is_alu: begin
            bus.BusSel = {1'b0, x};
            bus.Ain    = 1'b1;
            nxt        = T2;
          end
          is_mvnz: begin
            if (!bus.GZ) begin
              bus.BusSel = {1'b0, y};
              rin_en     = 1'b1;
            end
            bus.Done = 1'b1;
            nxt      = T0;
          end
          default: begin
            bus.Done = 1'b1;
            set_err  = 1'b1;
            nxt      = T0;
          end
        endcase
      end
      T2: begin
        bus.BusSel = {1'b0, y};
        bus.Gin    = 1'b1;
        bus.AluOp  = alu_of(op);
        nxt        = T3;
      end
      T3: begin
        bus.BusSel = SEL_G;
        rin_en     = 1'b1;
        bus.Done   = 1'b1;
        nxt        = T0;
      end
      default: nxt = T0;
    endcase
  end

  assign bus.Err = err_q;

  dec3to8 u_dec (
    .en  (rin_en),
    .sel (x),
    .y   (bus.Rin)
  );

endmodule

// File: tb/tb_proc_ctrl.sv
// Bench for proc_ctrl: directed vector table, reset corners,
// and random traffic against a per-instruction schedule model.
module tb_proc_ctrl;
  import proc_pkg::*;

  logic Clock = 1'b0;
  logic Resetn;

  proc_ctrl_if bus();

  proc_ctrl dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic       ain;
    logic       gin;
    logic [1:0] aluop;
    logic [3:0] bussel;
    logic       done;
    logic       err;
  } outs_t;

  typedef struct {
    logic [8:0] ir;
    bit         gz;
    bit         hold;
    int         ncyc;
    logic [3:0] sel;
    logic [7:0] rin;
    bit         err;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  bit         m_active;
  int         m_k;
  logic [8:0] m_ir;
  bit         m_err;
  outs_t      last;

  function automatic int exec_len(logic [2:0] op);
    return (op >= 3'd2 && op <= 3'd4) ? 3 : 1;
  endfunction

  function automatic bit illegal(logic [2:0] op);
    if (op == 3'd6 || op == 3'd7) return 1'b1;
`ifdef PROC_CTRL_MVNZ_EN
    return 1'b0;
`else
    return (op == 3'd5);
`endif
  endfunction

  // expected outputs for the k-th cycle after Run was accepted
  function automatic outs_t model_out(bit rstn, bit run, bit gz);
    outs_t o;
    logic [2:0] op;
    logic [2:0] x;
    logic [2:0] y;
    o  = '0;
    op = m_ir[8:6];
    x  = m_ir[5:3];
    y  = m_ir[2:0];
    if (!rstn) return o;
    o.err = m_err;
    if (!m_active) begin
      o.irin = run;
      return o;
    end
    o.done = (m_k == exec_len(op));
    case (op)
      3'd0: begin
        o.bussel = {1'b0, y};
        o.rin    = 8'(1 << x);
      end
      3'd1: begin
        o.bussel = 4'd9;
        o.rin    = 8'(1 << x);
      end
      3'd2, 3'd3, 3'd4: begin
        if (m_k == 1) begin
          o.bussel = {1'b0, x};
          o.ain    = 1'b1;
        end else if (m_k == 2) begin
          o.bussel = {1'b0, y};
          o.gin    = 1'b1;
          o.aluop  = 2'(op - 3'd2);
        end else begin
          o.bussel = 4'd8;
          o.rin    = 8'(1 << x);
        end
      end
`ifdef PROC_CTRL_MVNZ_EN
      3'd5: begin
        if (!gz) begin
          o.bussel = {1'b0, y};
          o.rin    = 8'(1 << x);
        end
      end
`endif
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t dut_out();
    return {bus.IRin, bus.Rin, bus.Ain, bus.Gin,
            bus.AluOp, bus.BusSel, bus.Done, bus.Err};
  endfunction

  task automatic check(string name, outs_t got, outs_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               name, got, exp, $time);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               name, got, exp, $time);
    end
  endtask

  // inputs are set at a falling edge; check, then advance one cycle
  task automatic step();
    if (!Resetn) begin
      m_active = 1'b0;
      m_err    = 1'b0;
    end
    #1;
    last = dut_out();
    check("cycle", last, model_out(Resetn, bus.Run, bus.GZ));
    @(posedge Clock);
    if (!Resetn) begin
      m_active = 1'b0;
      m_err    = 1'b0;
    end else if (!m_active) begin
      if (bus.Run) begin
        m_active = 1'b1;
        m_k      = 1;
        m_ir     = bus.IR;
      end
    end else if (m_k == exec_len(m_ir[8:6])) begin
      m_active = 1'b0;
      if (illegal(m_ir[8:6])) m_err = 1'b1;
    end else begin
      m_k++;
    end
    @(negedge Clock);
  endtask

  vec_t tbl[$];

  initial begin
    int cyc;
    bit seen;
    outs_t zero;
    zero = '0;

    tbl.push_back('{9'b000_011_101, 0, 0, 1, 4'd5, 8'h08, 0});
    tbl.push_back('{9'b010_001_010, 0, 0, 3, 4'd8, 8'h02, 0});
    tbl.push_back('{9'b011_001_010, 0, 0, 3, 4'd8, 8'h02, 0});
    tbl.push_back('{9'b100_110_110, 0, 0, 3, 4'd8, 8'h40, 0});
    tbl.push_back('{9'b001_111_000, 0, 1, 1, 4'd9, 8'h80, 0});
    tbl.push_back('{9'b000_000_000, 0, 0, 1, 4'd0, 8'h01, 0});
`ifdef PROC_CTRL_MVNZ_EN
    tbl.push_back('{9'b101_000_100, 1, 0, 1, 4'd0, 8'h00, 0});
    tbl.push_back('{9'b101_000_100, 0, 0, 1, 4'd4, 8'h01, 0});
`else
    tbl.push_back('{9'b101_000_100, 1, 0, 1, 4'd0, 8'h00, 1});
    tbl.push_back('{9'b101_000_100, 0, 0, 1, 4'd0, 8'h00, 1});
`endif
    tbl.push_back('{9'b111_010_011, 0, 0, 1, 4'd0, 8'h00, 1});
    tbl.push_back('{9'b000_100_001, 0, 0, 1, 4'd1, 8'h10, 1});

    m_active = 1'b0;
    m_err    = 1'b0;
    m_k      = 0;
    m_ir     = '0;

    Resetn  = 1'b0;
    bus.Run = 1'b1;
    bus.IR  = 9'h1ff;
    bus.GZ  = 1'b0;
    @(negedge Clock);
    #1;
    check("reset_outs", dut_out(), zero);
    step();
    Resetn  = 1'b1;
    bus.Run = 1'b0;
    step();
    step();
    check_int("idle_irin", int'(bus.IRin), 0);

    foreach (tbl[i]) begin
      bus.IR  = tbl[i].ir;
      bus.GZ  = tbl[i].gz;
      bus.Run = 1'b1;
      step();
      bus.Run = tbl[i].hold;
      cyc  = 0;
      seen = 1'b0;
      for (int j = 0; j < 6 && !seen; j++) begin
        step();
        cyc++;
        seen = last.done;
      end
      check_int("vec_cycles", cyc, tbl[i].ncyc);
      check_int("vec_bussel", int'(last.bussel), int'(tbl[i].sel));
      check_int("vec_rin", int'(last.rin), int'(tbl[i].rin));
      check_int("vec_err", int'(bus.Err), int'(tbl[i].err));
      if (!tbl[i].hold) begin
        bus.Run = 1'b0;
        step();
      end
    end

    // reset arrives during T2 of an add
    bus.Run = 1'b0;
    step();
    bus.IR  = 9'b010_001_010;
    bus.Run = 1'b1;
    step();
    bus.Run = 1'b0;
    step();
    Resetn = 1'b0;
    #1;
    check_int("t2_reset_gin", int'(bus.Gin), 0);
    step();
    step();
    Resetn = 1'b1;
    step();
    check_int("t2_reset_err", int'(bus.Err), 0);
    bus.Run = 1'b1;
    #1;
    check_int("t2_release_irin", int'(bus.IRin), 1);
    bus.Run = 1'b0;
    step();

    for (int n = 0; n < 600; n++) begin
      Resetn = ($urandom_range(0, 60) != 0);
      if (!m_active) bus.IR = 9'($urandom);
      bus.Run = 1'($urandom_range(0, 1));
      bus.GZ  = 1'($urandom_range(0, 1));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_ctrl.md
Name: proc_ctrl

Overview:
- Control unit for the bus-based processor datapath.
- Decodes a 9-bit instruction word and sequences, cycle by cycle, the load enables of the n-bit enable-flops: R0..R7, A, G and IR.
- Also drives the shared-bus select and the ALU op, and handshakes with the instruction source via Run/Done.
- Sits beside the datapath and owns no datapath storage except its own state and IR-decode fields.

Parameters:
- NREG, 8, number of general registers (fixed 8; 3-bit register fields).
- IW, 9, instruction width: IR[8:6]=opcode, IR[5:3]=X (dest), IR[2:0]=Y (source).

Ports:
- Clock  in  1  rising-edge clock.
- Resetn  in  1  asynchronous active-low reset.
- Run  in  1  start request; sampled only in state T0.
- IR  in  IW  instruction-register contents (output of the IR flop).
- GZ  in  1  G register contents == 0.
- IRin  out  1  load enable for the IR flop (IR loads from DIN).
- Rin  out  NREG  one-hot load enables, R0..R7.
- Ain  out  1  load enable for A.
- Gin  out  1  load enable for G.
- AluOp  out  2  ALU function: 00 add, 01 sub, 10 and.
- BusSel  out  4  bus source: 0-7 = R0..R7, 8 = G, 9 = DIN; other codes unused.
- Done  out  1  final cycle of the current instruction.
- Err  out  1  sticky illegal-opcode flag.

Behaviour:
- Reset
  - Resetn low asynchronously forces state T0 and clears Err.
  - While Resetn is low, every output is 0, including IRin, which is gated by Resetn.
  - Reset mid-instruction abandons it; no further enables follow.
- States: T0 (fetch/idle), T1, T2, T3. All outputs are combinational from state, IR and GZ.
- T0
  - IRin = Run.
  - If Run: go to T1; otherwise stay in T0.
  - No other enables.
- mv (000), T1: BusSel=Y, Rin[X]=1, Done=1 -> T0.
- mvi (001), T1: BusSel=9 (DIN), Rin[X]=1, Done=1 -> T0. The immediate must be valid on DIN during T1.
- add (010) / sub (011) / and (100)
  - T1: BusSel=X, Ain=1 -> T2.
  - T2: BusSel=Y, Gin=1, AluOp=00/01/10 -> T3.
  - T3: BusSel=8 (G), Rin[X]=1, Done=1 -> T0.
- Latency from Run-accepted edge: 2 cycles for mv/mvi, 4 cycles for ALU ops.
- Done is high for exactly one cycle per instruction.
- Run is ignored outside T0. Back-to-back instructions are allowed: Run high in the T0 following Done starts the next one.
- X == Y is legal for every op; e.g. add R2,R2 doubles R2.
- Default outputs in any cycle not listed above: Rin=0, Ain=Gin=0, AluOp=00, BusSel=0.
- Illegal opcodes (110, 111, and 101 when mvnz is not compiled in)
  - T1: Done=1, no enables; Err set on the next edge -> T0.
  - Err stays set until reset.

Optional Feature:
- Macro: PROC_CTRL_MVNZ_EN.
- Defined: opcode 101 = mvnz.
  - T1: if GZ==0, then BusSel=Y and Rin[X]=1; always Done=1 -> T0.
  - GZ is sampled combinationally in T1.
- Undefined: opcode 101 is illegal (Err set). The GZ input is present but unused.

Decomposition:
- Shared package proc_pkg holds:
  - opcode localparams (OP_MV..OP_MVNZ);
  - state encoding (T0..T3, 2 bits);
  - AluOp codes;
  - BusSel codes (SEL_G=8, SEL_DIN=9).
- One natural sub-module, dec3to8: 3-bit register field to one-hot 8-bit enable, with an enable input. It is used for Rin[X] generation.

Test Plan:
- Reset: Resetn low with Run=1 -> all outputs 0, Err=0. After release with Run=0 -> stays in T0, IRin=0.
- mv R3,R5 (IR=000_011_101), Run pulse:
  - T0: IRin=1.
  - Next cycle: BusSel=5, Rin=8'b0000_1000, Done=1.
  - Following cycle: back in T0.
- add R1,R2 (IR=010_001_010):
  - T1: BusSel=1, Ain.
  - T2: BusSel=2, Gin, AluOp=00.
  - T3: BusSel=8, Rin=8'b0000_0010, Done.
  - sub (IR=011_...) repeats the sequence with AluOp=01.
- mvi R7 (IR=001_111_000): T1 BusSel=9, Rin=8'b1000_0000, Done=1. Run held high -> next T0 IRin=1 with no idle cycle.
- Opcode 111: T1 Done=1, no enables; Err=1 afterwards. A subsequent legal mv executes normally and Err stays 1.
- With PROC_CTRL_MVNZ_EN, mvnz R0,R4:
  - GZ=1 -> Rin=0, Done=1.
  - GZ=0 -> BusSel=4, Rin=8'b0000_0001, Done=1.
- Reset asserted in T2 of an add -> Gin never asserts; state T0 after release.
